// File: rtl/regfile_pkg.sv
// Shared constants, the popcount helper and the write-port priority resolver
// for the scoreboarded register file.
package regfile_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 32;

    // Widest configuration the helper functions accept; callers zero-extend.
    localparam int MAX_REGS = 1024;
    localparam int MAX_AW   = 10;
    localparam int MAX_WR   = 8;
    localparam int WIDX_W   = 3;

    typedef struct packed {
        logic              vld;
        logic [WIDX_W-1:0] idx;
    } wr_sel_t;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Ascending scan, so the highest-indexed enabled port targeting a wins.
    function automatic wr_sel_t wr_resolve(input logic [MAX_WR-1:0]        en,
                                           input logic [MAX_WR*MAX_AW-1:0] addrs,
                                           input logic [MAX_AW-1:0]        a);
        wr_sel_t r;
        r = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (en[j] && addrs[j*MAX_AW +: MAX_AW] == a) begin
                r.vld = 1'b1;
                r.idx = WIDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count that is valid alongside the busy bits it describes.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_en_i,
    input  logic [AW-1:0]    issue_addr_i,
    input  logic [DEPTH-1:0] clear_i,
    output logic [DEPTH-1:0] busy_o,
    output logic [AW:0]      busy_count_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;

    // A new producer wins over a same-cycle writeback to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_en_i && issue_addr_i == AW'(i)) begin
                busy_d[i] = 1'b1;
            end else if (clear_i[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        count_d = (AW+1)'(popcount(MAX_REGS'(busy_d)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with prioritised write ports, optional zero
// register, write-first bypass on the registered reads and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD*DW-1:0] rd_data_async,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    output logic [AW:0]       busy_count,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    logic [MAX_WR-1:0]        wen_x;
    logic [MAX_WR*MAX_AW-1:0] waddr_x;
    logic [DW-1:0]            mem_q [DEPTH];
    logic [DW-1:0]            mem_d [DEPTH];
    logic [DW-1:0]            wr_val [DEPTH];
    logic [DEPTH-1:0]         wr_hit;
    logic [DEPTH-1:0]         busy;
    logic [NRD*DW-1:0]        rd_data_q, rd_data_d;
    logic [AW-1:0]            ra;
    wr_sel_t                  sel;

    function automatic logic [DW-1:0] array_read(input logic [AW-1:0] a);
        return (ZERO_REG != 0 && a == '0) ? '0 : mem_q[a];
    endfunction

    // Widen the write ports to the resolver's fixed layout.
    always_comb begin
        wen_x   = '0;
        waddr_x = '0;
        for (int j = 0; j < NWR; j++) begin
            wen_x[j]                      = wr_en[j];
            waddr_x[j*MAX_AW +: MAX_AW]   = MAX_AW'(wr_addr[j*AW +: AW]);
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel       = wr_resolve(wen_x, waddr_x, MAX_AW'(i));
            wr_hit[i] = sel.vld && !(ZERO_REG != 0 && i == 0);
            wr_val[i] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (sel.idx == WIDX_W'(j)) begin
                    wr_val[i] = wr_data[j*DW +: DW];
                end
            end
            mem_d[i] = wr_hit[i] ? wr_val[i] : mem_q[i];
        end
    end

    always_comb begin
        ra            = '0;
        rd_data_async = '0;
        rd_data_d     = '0;
        rd_busy       = '0;
        for (int k = 0; k < NRD; k++) begin
            ra                          = rd_addr[k*AW +: AW];
            rd_data_async[k*DW +: DW]   = array_read(ra);
            rd_data_d[k*DW +: DW]       = (BYPASS != 0 && wr_hit[ra]) ? wr_val[ra] : array_read(ra);
            rd_busy[k]                  = busy[ra];
        end
    end

    assign dbg_data = array_read(dbg_addr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .clear_i      (wr_hit),
        .busy_o       (busy),
        .busy_count_o (busy_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against a register/busy model
// in the default 32x32, two-read, two-write, zero-register, bypass setup.
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [63:0] rd_data_async;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [5:0]  busy_count;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg [32];
    logic        m_busy [32];

    regfile_sb dut (
        .clock         (clock),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_async (rd_data_async),
        .rd_busy       (rd_busy),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .issue_en      (issue_en),
        .issue_addr    (issue_addr),
        .busy_count    (busy_count),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic set_wr(input logic [1:0] en, input int a0, input int a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {5'(a1), 5'(a0)};
        wr_data = {d1, d0};
    endtask

    task automatic idle();
        wr_en    = '0;
        issue_en = 1'b0;
    endtask

    // One clock: check pre-edge views, advance the model, check registered views.
    task automatic tick();
        int ra;
        int wa;
        #1;
        for (int k = 0; k < 2; k++) begin
            ra = int'(rd_addr[k*5 +: 5]);
            chk("rd_data_async", rd_data_async[k*32 +: 32], m_reg[ra]);
            chk("rd_busy", 32'(rd_busy[k]), 32'(m_busy[ra]));
        end
        chk("dbg_data", dbg_data, m_reg[dbg_addr]);
        @(posedge clock);
        #1;
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j]) begin
                wa = int'(wr_addr[j*5 +: 5]);
                if (wa != 0) m_reg[wa] = wr_data[j*32 +: 32];
                m_busy[wa] = 1'b0;
            end
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ra = int'(rd_addr[k*5 +: 5]);
            chk("rd_data", rd_data[k*32 +: 32], m_reg[ra]);
        end
        chk("busy_count", 32'(busy_count), 32'(model_count()));
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clock);

        // Held in reset: every address reads zero and idle.
        for (int i = 0; i < 32; i++) begin
            set_rd(i, 31 - i);
            dbg_addr = 5'(i);
            #1;
            chk("reset_async", rd_data_async[31:0], 32'h0);
            chk("reset_busy", 32'(rd_busy[0]), 32'h0);
            chk("reset_dbg", dbg_data, 32'h0);
        end
        chk("reset_rd_data", rd_data[31:0], 32'h0);
        chk("reset_count", 32'(busy_count), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Two ports write r5 together: port 1 wins.
        set_rd(5, 0);
        set_wr(2'b11, 5, 5, 32'hDEADBEEF, 32'h12345678);
        tick();
        idle();
        #1;
        chk("prio_async_r5", rd_data_async[31:0], 32'h12345678);

        // Bypass: registered read sees same-cycle write, async shows old value.
        set_rd(7, 5);
        set_wr(2'b01, 7, 0, 32'hA5A5A5A5, 32'h0);
        #1;
        chk("bypass_old_async", rd_data_async[31:0], 32'h0);
        tick();
        chk("bypass_rd_data", rd_data[31:0], 32'hA5A5A5A5);
        idle();

        // Zero register ignores writes and issues.
        set_rd(0, 7);
        set_wr(2'b01, 0, 0, 32'hFFFFFFFF, 32'h0);
        issue_en   = 1'b1;
        issue_addr = 5'd0;
        tick();
        idle();
        #1;
        chk("zero_rd_data", rd_data[31:0], 32'h0);
        chk("zero_async", rd_data_async[31:0], 32'h0);
        chk("zero_busy", 32'(rd_busy[0]), 32'h0);
        chk("zero_count", 32'(busy_count), 32'h0);

        // Scoreboard counting and issue-beats-write.
        issue_en = 1'b1;
        issue_addr = 5'd3; tick(); chk("cnt_after_r3", 32'(busy_count), 32'd1);
        issue_addr = 5'd4; tick(); chk("cnt_after_r4", 32'(busy_count), 32'd2);
        issue_addr = 5'd9; tick(); chk("cnt_after_r9", 32'(busy_count), 32'd3);
        set_rd(4, 3);
        set_wr(2'b01, 4, 0, 32'h00000044, 32'h0);
        issue_addr = 5'd4;
        tick();
        chk("issue_wins_busy", 32'(rd_busy[0]), 32'h1);
        chk("issue_wins_count", 32'(busy_count), 32'd3);
        issue_en = 1'b0;
        set_wr(2'b01, 3, 0, 32'h00000033, 32'h0);
        tick();
        chk("clear_r3_count", 32'(busy_count), 32'd2);
        chk("clear_r3_busy", 32'(rd_busy[1]), 32'h0);
        idle();

        // Randomized traffic with deliberate address collisions.
        for (int n = 0; n < 300; n++) begin
            set_wr(2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                   $urandom, $urandom);
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            set_rd(($urandom_range(0, 2) == 0) ? int'(wr_addr[4:0]) : $urandom_range(0, 31),
                   ($urandom_range(0, 2) == 0) ? int'(wr_addr[9:5]) : $urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            tick();
        end
        idle();

        // Reset mid-operation clears everything at once.
        set_wr(2'b11, 1, 2, 32'h11111111, 32'h22222222);
        tick();
        set_wr(2'b01, 3, 0, 32'h33333333, 32'h0);
        issue_en   = 1'b1;
        issue_addr = 5'd2;
        set_rd(2, 1);
        dbg_addr = 5'd3;
        tick();
        idle();
        reset = 1'b0;
        #1;
        chk("midreset_rd0", rd_data[31:0], 32'h0);
        chk("midreset_rd1", rd_data[63:32], 32'h0);
        chk("midreset_async0", rd_data_async[31:0], 32'h0);
        chk("midreset_async1", rd_data_async[63:32], 32'h0);
        chk("midreset_busy", 32'(rd_busy), 32'h0);
        chk("midreset_count", 32'(busy_count), 32'h0);
        chk("midreset_dbg", dbg_data, 32'h0);
        model_clear();
        reset = 1'b1;
        set_rd(2, 3);
        tick();
        chk("post_reset_r2", rd_data[31:0], 32'h0);
        chk("post_reset_r2_busy", 32'(rd_busy[0]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
